mem_arbiter: RTL and testbench
==============================

MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter MAX_WAIT, default 4: the maximum number of consecutive cycles a pending debug request waits behind CPU grants.
REQ-002 clk  in  1  single system clock; all state updates on posedge.
REQ-003 reset  in  1  asynchronous, active-high reset.
REQ-004 cpu_req  in  1  CPU access request this cycle.
REQ-005 cpu_we  in  1  CPU write enable; 0 = read.
REQ-006 cpu_addr  in  16  CPU address.
REQ-007 cpu_wdata  in  16  CPU write data.
REQ-008 cpu_stall  out  1  CPU access not granted this cycle; the CPU holds its request.
REQ-009 cpu_rvalid  out  1  CPU read data valid.
REQ-010 cpu_rdata  out  16  CPU read data.
REQ-011 dbg_valid  in  1  debug/loader request valid.
REQ-012 dbg_we  in  1  debug write enable.
REQ-013 dbg_addr  in  16  debug address.
REQ-014 dbg_wdata  in  16  debug write data.
REQ-015 dbg_lock  in  1  debug bulk-access lock request.
REQ-016 dbg_ready  out  1  debug request accepted this cycle.
REQ-017 dbg_rvalid  out  1  debug read data valid.
REQ-018 dbg_rdata  out  16  debug read data.
REQ-019 locked  out  1  the arbiter is in the LOCK state.
REQ-020 mem_address  out  16  address driven to the memory map.
REQ-021 mem_in  out  16  write data driven to the memory map.
REQ-022 mem_load  out  1  write strobe to the memory map.
REQ-023 mem_out  in  16  memory read data, valid one cycle after mem_address is presented.

Function
REQ-024 The arbiter SHALL grant at most one requester per cycle; a grant is a combinational decision from the current inputs and state.
REQ-025 The arbiter SHALL have states RUN and LOCK.
- RUN -> LOCK when dbg_lock=1 and no CPU read is outstanding.
- LOCK -> RUN when dbg_lock=0.
REQ-026 In RUN, the debug port SHALL be granted when:
- dbg_valid=1, and
- either cpu_req=0 or starve_cnt==MAX_WAIT.
Otherwise the CPU SHALL be granted when cpu_req=1.
REQ-027 In LOCK, only the debug port SHALL be granted; cpu_stall SHALL equal cpu_req.
REQ-028 starve_cnt (3 bits) SHALL behave as follows:
- increments when dbg_valid=1 and the CPU is granted;
- saturates at MAX_WAIT;
- clears on any debug grant or when dbg_valid=0.
REQ-029 cpu_stall SHALL equal cpu_req AND NOT cpu_grant; dbg_ready SHALL equal dbg_grant.
REQ-030 mem_address, mem_in and mem_load SHALL carry the granted requester's addr, wdata and we.
- With no grant: mem_load=0 and mem_address=0.
REQ-031 Granted reads (we=0) SHALL pulse the owner's rvalid for one cycle exactly one cycle after the grant, with rdata = mem_out.
REQ-032 A registered owner tag SHALL route mem_out to the correct requester.
- rdata of the non-owner SHALL hold its last value.
REQ-033 Granted writes SHALL produce no rvalid pulse.
REQ-034 Back-to-back grants SHALL be supported, sustaining one access per cycle with no bubble, including alternating owners.
REQ-035 dbg_lock asserted during a cycle with an outstanding CPU read SHALL take effect only after that read's rvalid cycle.

Reset
REQ-036 While reset=1, and immediately upon its assertion:
- state = RUN, starve_cnt = 0, owner tag cleared;
- cpu_rvalid, dbg_rvalid, dbg_ready, mem_load and locked = 0;
- cpu_rdata and dbg_rdata = 0.
REQ-037 A read in flight at reset assertion SHALL be dropped, with no rvalid pulse after reset release.

Verification
REQ-038 cpu_req=1, cpu_we=0, cpu_addr=0x0010 with mem_out=0x1234 on the next cycle -> cpu_stall=0, and cpu_rvalid=1 with cpu_rdata=0x1234 exactly one cycle later.
REQ-039 cpu_req and dbg_valid both held at 1 with MAX_WAIT=4:
- the CPU is granted for 4 cycles;
- dbg_ready=1 with cpu_stall=1 on the 5th cycle;
- starve_cnt=0 afterwards.
REQ-040 dbg_valid=1, dbg_we=1, dbg_addr=0x4000, dbg_wdata=0x00FF with cpu_req=0 -> same-cycle dbg_ready=1, mem_load=1, mem_address=0x4000 and mem_in=0x00FF; no dbg_rvalid.
REQ-041 dbg_lock=1 while cpu_req=1 -> locked=1 the next cycle, cpu_stall=1 for every locked cycle, and CPU grants resume the cycle after dbg_lock=0.
REQ-042 Alternating CPU and debug reads on consecutive cycles -> each rvalid on its own port one cycle after its grant, with the correct mem_out value routed.
REQ-043 reset pulsed in the cycle after a granted CPU read -> no cpu_rvalid, all outputs at reset values, and normal arbitration after release.

Source files
------------

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one memory-map port between a CPU and a debug/loader port.
//
// Ports:
//   clk, reset                   system clock, asynchronous active-high reset
//   cpu_req/we/addr/wdata        CPU access request; cpu_stall when not granted
//   cpu_rvalid/rdata             CPU read return, one cycle after a read grant
//   dbg_valid/we/addr/wdata      debug access request; dbg_ready when granted
//   dbg_lock                     debug bulk-access lock request
//   dbg_rvalid/rdata             debug read return, one cycle after a read grant
//   locked                       arbiter currently in the lock state
//   mem_address/mem_in/mem_load  request driven to the memory map
//   mem_out                      memory read data, valid one cycle after the address
//
// Grants are combinational. The CPU normally wins, but a waiting debug request
// is forced through after MAX_WAIT consecutive CPU grants. In the lock state
// only the debug port is served.
module mem_arbiter #(
  parameter int unsigned MAX_WAIT = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        cpu_req,
  input  logic        cpu_we,
  input  logic [15:0] cpu_addr,
  input  logic [15:0] cpu_wdata,
  output logic        cpu_stall,
  output logic        cpu_rvalid,
  output logic [15:0] cpu_rdata,
  input  logic        dbg_valid,
  input  logic        dbg_we,
  input  logic [15:0] dbg_addr,
  input  logic [15:0] dbg_wdata,
  input  logic        dbg_lock,
  output logic        dbg_ready,
  output logic        dbg_rvalid,
  output logic [15:0] dbg_rdata,
  output logic        locked,
  output logic [15:0] mem_address,
  output logic [15:0] mem_in,
  output logic        mem_load,
  input  logic [15:0] mem_out
);

  typedef enum logic {StRun, StLock} state_e;
  typedef enum logic [1:0] {OwnNone, OwnCpu, OwnDbg} owner_e;

  localparam logic [2:0] WaitMax = 3'(MAX_WAIT);

  state_e      state_q;
  logic [2:0]  starve_cnt_q;
  owner_e      owner_q;          // requester whose read data arrives this cycle
  logic [15:0] cpu_rdata_q;
  logic [15:0] dbg_rdata_q;

  logic cpu_grant;
  logic dbg_grant;

  // Grants are suppressed during reset so nothing reaches the memory map.
  always_comb begin
    cpu_grant = 1'b0;
    dbg_grant = 1'b0;
    if (!reset) begin
      if (state_q == StLock) begin
        dbg_grant = dbg_valid;
      end else begin
        dbg_grant = dbg_valid && (!cpu_req || (starve_cnt_q == WaitMax));
        cpu_grant = cpu_req && !dbg_grant;
      end
    end
  end

  always_comb begin
    mem_address = 16'h0000;
    mem_in      = 16'h0000;
    mem_load    = 1'b0;
    if (dbg_grant) begin
      mem_address = dbg_addr;
      mem_in      = dbg_wdata;
      mem_load    = dbg_we;
    end else if (cpu_grant) begin
      mem_address = cpu_addr;
      mem_in      = cpu_wdata;
      mem_load    = cpu_we;
    end
  end

  assign cpu_stall  = cpu_req && !cpu_grant;
  assign dbg_ready  = dbg_grant;
  assign locked     = (state_q == StLock);
  assign cpu_rvalid = (owner_q == OwnCpu);
  assign dbg_rvalid = (owner_q == OwnDbg);

  // Read data is passed straight through in the rvalid cycle, then held.
  assign cpu_rdata = cpu_rvalid ? mem_out : cpu_rdata_q;
  assign dbg_rdata = dbg_rvalid ? mem_out : dbg_rdata_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= StRun;
      starve_cnt_q <= 3'd0;
      owner_q      <= OwnNone;
      cpu_rdata_q  <= 16'h0000;
      dbg_rdata_q  <= 16'h0000;
    end else begin
      unique case (state_q)
        // A CPU read returning this cycle must complete before locking.
        StRun:   if (dbg_lock && (owner_q != OwnCpu)) state_q <= StLock;
        StLock:  if (!dbg_lock) state_q <= StRun;
        default: state_q <= StRun;
      endcase

      if (!dbg_valid || dbg_grant) begin
        starve_cnt_q <= 3'd0;
      end else if (cpu_grant && (starve_cnt_q != WaitMax)) begin
        starve_cnt_q <= starve_cnt_q + 3'd1;
      end

      if (cpu_grant && !cpu_we) begin
        owner_q <= OwnCpu;
      end else if (dbg_grant && !dbg_we) begin
        owner_q <= OwnDbg;
      end else begin
        owner_q <= OwnNone;
      end

      if (cpu_rvalid) cpu_rdata_q <= mem_out;
      if (dbg_rvalid) dbg_rdata_q <= mem_out;
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
module tb_mem_arbiter;

  localparam int MW = 4;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        cpu_req, cpu_we;
  logic [15:0] cpu_addr, cpu_wdata;
  logic        cpu_stall, cpu_rvalid;
  logic [15:0] cpu_rdata;
  logic        dbg_valid, dbg_we, dbg_lock;
  logic [15:0] dbg_addr, dbg_wdata;
  logic        dbg_ready, dbg_rvalid;
  logic [15:0] dbg_rdata;
  logic        locked;
  logic [15:0] mem_address, mem_in, mem_out;
  logic        mem_load;

  mem_arbiter #(.MAX_WAIT(MW)) dut (
    .clk(clk), .reset(reset),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_stall(cpu_stall), .cpu_rvalid(cpu_rvalid), .cpu_rdata(cpu_rdata),
    .dbg_valid(dbg_valid), .dbg_we(dbg_we), .dbg_addr(dbg_addr), .dbg_wdata(dbg_wdata),
    .dbg_lock(dbg_lock), .dbg_ready(dbg_ready), .dbg_rvalid(dbg_rvalid),
    .dbg_rdata(dbg_rdata), .locked(locked),
    .mem_address(mem_address), .mem_in(mem_in), .mem_load(mem_load), .mem_out(mem_out)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  // Reference model state
  bit          m_lock;
  int          m_wait;     // consecutive CPU grants the debug request has waited
  int          m_pend;     // 0 none, 1 CPU read returns next cycle, 2 debug read
  logic [15:0] m_cpu_rd, m_dbg_rd;

  // Values observed at the last check point, for directed checks
  logic o_stall, o_ready, o_locked, o_crv, o_drv, o_load;
  logic [15:0] o_crd, o_drd, o_addr, o_in;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_lock = 0; m_wait = 0; m_pend = 0; m_cpu_rd = '0; m_dbg_rd = '0;
  endtask

  // One clock cycle: inputs were set at posedge+1; check before the next edge.
  task automatic cycle();
    bit dg, cg;
    logic [15:0] ea, ei;
    logic el;
    #3;
    if (m_lock) begin
      dg = dbg_valid; cg = 0;
    end else begin
      dg = dbg_valid && (!cpu_req || m_wait == MW);
      cg = cpu_req && !dg;
    end
    ea = '0; ei = '0; el = 0;
    if (dg) begin
      ea = dbg_addr; ei = dbg_wdata; el = dbg_we;
    end else if (cg) begin
      ea = cpu_addr; ei = cpu_wdata; el = cpu_we;
    end
    o_stall = cpu_stall; o_ready = dbg_ready; o_locked = locked;
    o_crv = cpu_rvalid; o_drv = dbg_rvalid; o_crd = cpu_rdata; o_drd = dbg_rdata;
    o_addr = mem_address; o_in = mem_in; o_load = mem_load;
    chk("cpu_stall", 16'(cpu_stall), 16'(cpu_req && !cg));
    chk("dbg_ready", 16'(dbg_ready), 16'(dg));
    chk("locked", 16'(locked), 16'(m_lock));
    chk("mem_address", mem_address, ea);
    chk("mem_load", 16'(mem_load), 16'(el));
    if (dg || cg) chk("mem_in", mem_in, ei);
    chk("cpu_rvalid", 16'(cpu_rvalid), 16'(m_pend == 1));
    chk("dbg_rvalid", 16'(dbg_rvalid), 16'(m_pend == 2));
    chk("cpu_rdata", cpu_rdata, (m_pend == 1) ? mem_out : m_cpu_rd);
    chk("dbg_rdata", dbg_rdata, (m_pend == 2) ? mem_out : m_dbg_rd);
    // advance the model
    if (m_pend == 1) m_cpu_rd = mem_out;
    if (m_pend == 2) m_dbg_rd = mem_out;
    if (!m_lock && dbg_lock && m_pend != 1) m_lock = 1;
    else if (m_lock && !dbg_lock) m_lock = 0;
    if (!dbg_valid || dg) m_wait = 0;
    else if (cg && m_wait < MW) m_wait = m_wait + 1;
    m_pend = (cg && !cpu_we) ? 1 : (dg && !dbg_we) ? 2 : 0;
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    reset = 1'b1;
    #1;
    chk("rst_cpu_rvalid", 16'(cpu_rvalid), 16'h0);
    chk("rst_dbg_rvalid", 16'(dbg_rvalid), 16'h0);
    chk("rst_dbg_ready", 16'(dbg_ready), 16'h0);
    chk("rst_mem_load", 16'(mem_load), 16'h0);
    chk("rst_mem_address", mem_address, 16'h0);
    chk("rst_locked", 16'(locked), 16'h0);
    chk("rst_cpu_rdata", cpu_rdata, 16'h0);
    chk("rst_dbg_rdata", dbg_rdata, 16'h0);
    @(posedge clk);
    @(posedge clk);
    #1;
    reset = 1'b0;
    model_reset();
  endtask

  task automatic idle();
    cpu_req = 0; cpu_we = 0; dbg_valid = 0; dbg_we = 0; dbg_lock = 0;
  endtask

  initial begin
    cpu_req = 0; cpu_we = 0; cpu_addr = '0; cpu_wdata = '0;
    dbg_valid = 1; dbg_we = 1; dbg_addr = 16'h0055; dbg_wdata = '0; dbg_lock = 0;
    mem_out = 16'hdead;
    model_reset();
    #2;
    apply_reset();
    idle();

    // CPU read returns mem_out one cycle later
    cpu_req = 1; cpu_addr = 16'h0010; mem_out = 16'h0bad;
    cycle();
    chk("r38_stall", 16'(o_stall), 16'h0);
    chk("r38_addr", o_addr, 16'h0010);
    cpu_req = 0; mem_out = 16'h1234;
    cycle();
    chk("r38_rvalid", 16'(o_crv), 16'h1);
    chk("r38_rdata", o_crd, 16'h1234);

    // Starvation limit: CPU wins MW times, then debug
    cpu_req = 1; cpu_we = 1; dbg_valid = 1; dbg_we = 1; dbg_addr = 16'h0200;
    for (int i = 0; i < MW; i++) begin
      cpu_addr = 16'(i); mem_out = 16'(i + 7);
      cycle();
      chk("r39_cpu_won", 16'({o_stall, o_ready}), 16'b00);
    end
    cycle();
    chk("r39_dbg_won", 16'({o_stall, o_ready}), 16'b11);
    cycle();
    chk("r39_cnt_cleared", 16'({o_stall, o_ready}), 16'b00);
    idle();
    cycle();

    // Debug write with idle CPU
    dbg_valid = 1; dbg_we = 1; dbg_addr = 16'h4000; dbg_wdata = 16'h00ff;
    cycle();
    chk("r40_ready", 16'(o_ready), 16'h1);
    chk("r40_load", 16'(o_load), 16'h1);
    chk("r40_addr", o_addr, 16'h4000);
    chk("r40_in", o_in, 16'h00ff);
    idle();
    cycle();
    chk("r40_no_rvalid", 16'(o_drv), 16'h0);

    // Lock with CPU requesting
    dbg_lock = 1; cpu_req = 1; cpu_we = 0; cpu_addr = 16'h0123;
    cycle();
    for (int i = 0; i < 3; i++) begin
      dbg_valid = 1'(i & 1); dbg_we = 0; mem_out = 16'(16'h3000 + i);
      cycle();
      chk("r41_locked", 16'(o_locked), 16'h1);
      chk("r41_stall", 16'(o_stall), 16'h1);
    end
    dbg_lock = 0; dbg_valid = 0;
    cycle();
    chk("r41_still_locked", 16'(o_stall), 16'h1);
    cycle();
    chk("r41_resumed", 16'({o_locked, o_stall}), 16'b00);
    idle();
    cycle();

    // Alternating CPU / debug reads, back to back
    for (int i = 0; i < 6; i++) begin
      cpu_req = !i[0]; cpu_we = 0; cpu_addr = 16'(16'h0100 + i);
      dbg_valid = i[0]; dbg_we = 0; dbg_addr = 16'(16'h0800 + i);
      mem_out = 16'(16'ha000 + i);
      cycle();
      if (i > 0) chk("r42_routed", 16'({o_crv, o_drv}), i[0] ? 16'b10 : 16'b01);
    end
    idle(); mem_out = 16'hbeef;
    cycle();

    // Reset while a CPU read is in flight
    cpu_req = 1; cpu_we = 0; cpu_addr = 16'h0042;
    cycle();
    apply_reset();
    cpu_req = 0;
    cycle();
    chk("r43_no_rvalid", 16'(o_crv), 16'h0);
    cpu_req = 1; cpu_addr = 16'h0043;
    cycle();
    chk("r43_granted", 16'(o_stall), 16'h0);
    cpu_req = 0; mem_out = 16'h7777;
    cycle();
    chk("r43_rdata", o_crd, 16'h7777);

    // Random traffic against the model
    idle();
    for (int i = 0; i < 400; i++) begin
      cpu_req = ($urandom_range(0, 3) != 0);
      cpu_we = $urandom_range(0, 1) == 1;
      cpu_addr = 16'($urandom); cpu_wdata = 16'($urandom);
      dbg_valid = $urandom_range(0, 1) == 1;
      dbg_we = $urandom_range(0, 1) == 1;
      dbg_addr = 16'($urandom); dbg_wdata = 16'($urandom);
      if ($urandom_range(0, 15) == 0) dbg_lock = !dbg_lock;
      mem_out = 16'($urandom);
      cycle();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
